// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART RX frame controller: start detect, bit timing, deserialize, parity/stop check
module uart_rx_ctrl #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               par_en,
  input  logic               par_typ,
  input  logic               sampled_bit,
  input  logic               sample_done,
  output logic               data_sampled_en,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic [DATA_W-1:0]  p_data,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err,
  output logic               strt_glitch,
  output logic               busy
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PRESC_W-1:0]  r_presc;
  logic [PRESC_W-1:0]  r_edge_cnt;
  logic [3:0]          r_bit_cnt;
  logic                r_got_bit;
  logic                r_bit_val;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_p_data;
  logic                r_data_valid;
  logic                r_par_err;
  logic                r_stp_err;
  logic                r_glitch;

  logic w_presc_ok;
  logic w_eob;
  logic w_cap;
  logic w_have;
  logic w_period_bit;
  logic w_par_exp;
  logic w_glitch;
  logic w_frame_done;
  logic w_par_err_nxt;
  logic w_stp_err_nxt;

  assign w_presc_ok = (prescale == PRESC_W'(8)) || (prescale == PRESC_W'(16)) ||
                      (prescale == PRESC_W'(32));
  assign w_eob      = (r_edge_cnt == r_presc - 1'b1);
  assign w_cap      = sample_done & ~r_got_bit;
  assign w_have     = w_cap | r_got_bit;
  // Value of the current bit period; a period with no capture reads as 0.
  assign w_period_bit = w_cap ? sampled_bit : (r_got_bit & r_bit_val);
  assign w_par_exp  = (^r_shift) ^ par_typ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_glitch     = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rx_in && w_presc_ok) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_cap && sampled_bit) begin
          w_state_nxt = S_IDLE;
          w_glitch    = 1'b1;
        end else if (w_eob) begin
          if (w_have) begin
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
            w_glitch    = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_eob && (r_bit_cnt == 4'(DATA_W))) w_state_nxt = par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_eob) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_eob) begin
          w_state_nxt  = S_IDLE;
          w_frame_done = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_par_err_nxt = r_par_err;
    w_stp_err_nxt = r_stp_err;
    if (r_state == S_PARITY) begin
      if (w_cap && (sampled_bit != w_par_exp)) w_par_err_nxt = 1'b1;
      if (w_eob && !w_have)                    w_par_err_nxt = 1'b1;
    end
    if (r_state == S_STOP) begin
      if (w_cap && !sampled_bit) w_stp_err_nxt = 1'b1;
      if (w_eob && !w_have)      w_stp_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc      <= '0;
      r_edge_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_got_bit    <= 1'b0;
      r_bit_val    <= 1'b0;
      r_shift      <= '0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      r_glitch     <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_glitch     <= w_glitch;
      if (r_state == S_IDLE) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= '0;
        r_got_bit  <= 1'b0;
        if (w_state_nxt == S_START) begin
          r_presc   <= prescale;
          r_par_err <= 1'b0;
          r_stp_err <= 1'b0;
        end
      end else begin
        r_par_err <= w_par_err_nxt;
        r_stp_err <= w_stp_err_nxt;
        if (w_state_nxt == S_IDLE) begin
          r_edge_cnt <= '0;
          r_bit_cnt  <= '0;
          r_got_bit  <= 1'b0;
        end else if (w_eob) begin
          r_edge_cnt <= '0;
          r_bit_cnt  <= r_bit_cnt + 4'd1;
          r_got_bit  <= 1'b0;
        end else begin
          r_edge_cnt <= r_edge_cnt + 1'b1;
          if (w_cap) begin
            r_got_bit <= 1'b1;
            r_bit_val <= sampled_bit;
          end
        end
        if ((r_state == S_DATA) && w_eob) r_shift <= {w_period_bit, r_shift[DATA_W-1:1]};
        // Errors raised on the final STOP cycle still suppress the byte.
        if (w_frame_done && !w_par_err_nxt && !w_stp_err_nxt) begin
          r_p_data     <= r_shift;
          r_data_valid <= 1'b1;
        end
      end
    end
  end

  assign busy            = (r_state != S_IDLE);
  assign data_sampled_en = busy;
  assign edge_cnt        = r_edge_cnt;
  assign bit_cnt         = r_bit_cnt;
  assign p_data          = r_p_data;
  assign data_valid      = r_data_valid;
  assign par_err         = r_par_err;
  assign stp_err         = r_stp_err;
  assign strt_glitch     = r_glitch;

endmodule
